// File: rtl/gray_rx_checker_pkg.sv
// Shared encodings for the Gray-code receive checker: step classes and tracker states.
package gray_pkg;

  localparam logic [1:0] STEP_HOLD = 2'b00;
  localparam logic [1:0] STEP_UP   = 2'b01;
  localparam logic [1:0] STEP_DOWN = 2'b10;
  localparam logic [1:0] STEP_JUMP = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/gray_rx_checker_gray_to_bin.sv
// Combinational Gray-to-binary decoder; reusable by any consumer of the converter output.
module gray_to_bin #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // MSB passes through; each lower bit folds in the decoded bit above it
  always_comb begin
    bin = gray;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Gray-code stream checker: decodes each accepted sample, classifies the step against
// the previous sample and keeps a saturating count of illegal jumps.
module gray_rx_checker
  import gray_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_gray,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_bin,
  output logic [1:0]           out_step,
  output logic                 out_first,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] prev_bin_r;
  logic [WIDTH-1:0] prev_inc_s;
  logic [WIDTH-1:0] prev_dec_s;
  logic [1:0]       step_s;
  logic             first_s;
  logic             accept_s;

  assign in_ready   = !out_valid || out_ready;
  assign accept_s   = in_valid && in_ready;
  // Kept at WIDTH bits so max+1 wraps to 0 and 0-1 wraps to max
  assign prev_inc_s = prev_bin_r + WIDTH'(1'b1);
  assign prev_dec_s = prev_bin_r - WIDTH'(1'b1);

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray (in_gray),
    .bin  (bin_s)
  );

  // Next-state and step classification for the sample offered this cycle
  always_comb begin
    state_nxt_s = state_r;
    step_s      = STEP_HOLD;
    first_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_TRACK;
          first_s     = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_TRACK: begin
        if (bin_s == prev_bin_r) begin
          step_s = STEP_HOLD;
        end else if (bin_s == prev_inc_s) begin
          step_s = STEP_UP;
        end else if (bin_s == prev_dec_s) begin
          step_s = STEP_DOWN;
        end else begin
          step_s = STEP_JUMP;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Result register, tracker state, last decoded value and saturating jump counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      prev_bin_r <= '0;
      out_valid  <= 1'b0;
      out_bin    <= '0;
      out_step   <= STEP_HOLD;
      out_first  <= 1'b0;
      out_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        out_valid  <= 1'b1;
        out_bin    <= bin_s;
        out_step   <= step_s;
        out_first  <= first_s;
        out_err    <= (step_s == STEP_JUMP);
        prev_bin_r <= bin_s;
        if ((step_s == STEP_JUMP) && (err_count != {ERR_CNT_W{1'b1}})) begin
          err_count <= err_count + ERR_CNT_W'(1'b1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: directed scenarios on a 2-bit instance with a 2-bit counter,
// plus a randomized run on a 4-bit instance against an arithmetic reference model.
module tb_gray_rx_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, out_first, out_err;
  logic [1:0] in_gray, out_bin, out_step, err_count;

  logic       w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_first, w_out_err;
  logic [3:0] w_in_gray, w_out_bin;
  logic [1:0] w_out_step;
  logic [7:0] w_err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_rx_checker #(.WIDTH(2), .ERR_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_gray(in_gray), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .out_step(out_step),
    .out_first(out_first), .out_err(out_err), .err_count(err_count)
  );

  gray_rx_checker #(.WIDTH(4), .ERR_CNT_W(8)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_gray(w_in_gray), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_bin(w_out_bin),
    .out_step(w_out_step), .out_first(w_out_first), .out_err(w_out_err),
    .err_count(w_err_count)
  );

  // Drive one cycle on the 2-bit instance, then step past the edge
  task automatic drive(input logic v, input logic [1:0] g, input logic rdy);
    in_valid  = v;
    in_gray   = g;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    w_in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_valid, out_bin, out_step, out_first, out_err, err_count, in_ready} !== 10'b0_00_00_0_0_00_1) begin
      bad++;
      $display("FAIL reset_state got v=%b bin=%0d step=%0d first=%b err=%b cnt=%0d rdy=%b want 0,0,0,0,0,0,1",
               out_valid, out_bin, out_step, out_first, out_err, err_count, in_ready);
    end
    total++;
    if ({w_out_valid, w_err_count} !== 9'd0) begin
      bad++;
      $display("FAIL reset_wide got v=%b cnt=%0d want 0,0", w_out_valid, w_err_count);
    end
  endtask

  task automatic test_count_up();
    logic [1:0] gseq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] bseq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [8:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, gseq[i], 1'b1);
      exp = {1'b1, bseq[i], (i == 0) ? 2'b00 : 2'b01, (i == 0), 1'b0, 2'd0};
      total++;
      if ({out_valid, out_bin, out_step, out_first, out_err, err_count} !== exp) begin
        bad++;
        $display("FAIL count_up[%0d] got %b want %b", i, {out_valid, out_bin, out_step, out_first, out_err, err_count}, exp);
      end
    end
    drive(1'b0, 2'b00, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_idle got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_count_down();
    logic [1:0] gseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] bseq [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
    logic [8:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, gseq[i], 1'b1);
      exp = {1'b1, bseq[i], (i == 0) ? 2'b00 : 2'b10, (i == 0), 1'b0, 2'd0};
      total++;
      if ({out_valid, out_bin, out_step, out_first, out_err, err_count} !== exp) begin
        bad++;
        $display("FAIL count_down[%0d] got %b want %b", i, {out_valid, out_bin, out_step, out_first, out_err, err_count}, exp);
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    drive(1'b1, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b1);
    total++;
    if ({out_bin, out_step, out_err, err_count} !== {2'd2, 2'b11, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL jump got bin=%0d step=%0d err=%b cnt=%0d want 2,3,1,1", out_bin, out_step, out_err, err_count);
    end
    drive(1'b1, 2'b11, 1'b1);
    total++;
    if ({out_bin, out_step, out_err, err_count} !== {2'd2, 2'b00, 1'b0, 2'd1}) begin
      bad++;
      $display("FAIL jump_hold got bin=%0d step=%0d err=%b cnt=%0d want 2,0,0,1", out_bin, out_step, out_err, err_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_gray = 2'b11; out_ready = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, out_bin, out_step, out_first} !== {1'b0, 1'b1, 2'd1, 2'b00, 1'b1}) begin
        bad++;
        $display("FAIL stall[%0d] got rdy=%b v=%b bin=%0d step=%0d first=%b want 0,1,1,0,1",
                 i, in_ready, out_valid, out_bin, out_step, out_first);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_ready got in_ready=%b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_bin, out_step, out_first} !== {1'b1, 2'd2, 2'b01, 1'b0}) begin
      bad++;
      $display("FAIL drain_accept got v=%b bin=%0d step=%0d first=%b want 1,2,1,0", out_valid, out_bin, out_step, out_first);
    end
    drive(1'b0, 2'b00, 1'b1);
    total++;
    if ({out_valid, err_count} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL single_drain got v=%b cnt=%0d want 0,0", out_valid, err_count);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] cexp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1'b1);
      total++;
      if (err_count !== cexp[i]) begin
        bad++;
        $display("FAIL saturate[%0d] got cnt=%0d want %0d", i, err_count, cexp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 2'b00, 1'b1);
    drive(1'b1, 2'b11, 1'b1);
    rst = 1'b1;
    drive(1'b1, 2'b01, 1'b1);
    rst = 1'b0;
    total++;
    if ({out_valid, err_count} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_mid got v=%b cnt=%0d want 0,0", out_valid, err_count);
    end
    drive(1'b1, 2'b11, 1'b1);
    total++;
    if ({out_valid, out_bin, out_step, out_first, out_err, err_count} !== {1'b1, 2'd2, 2'b00, 1'b1, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL after_reset got v=%b bin=%0d step=%0d first=%b err=%b cnt=%0d want 1,2,0,1,0,0",
               out_valid, out_bin, out_step, out_first, out_err, err_count);
    end
    in_valid = 1'b0;
  endtask

  // Randomized traffic on the 4-bit instance against an arithmetic model
  task automatic test_random();
    logic       m_valid = 1'b0, m_started = 1'b0, m_first = 1'b0;
    logic [3:0] m_bin = 4'd0, m_prev = 4'd0, b, g;
    logic [1:0] m_step = 2'd0;
    int         m_cnt = 0;
    int         diff;
    logic       iv, ordy;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      total++;
      if (w_out_valid !== m_valid || w_err_count !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL rand_state[%0d] got v=%b cnt=%0d want %b,%0d", c, w_out_valid, w_err_count, m_valid, m_cnt);
      end
      if (m_valid) begin
        total++;
        if ({w_out_bin, w_out_step, w_out_first, w_out_err} !== {m_bin, m_step, m_first, (m_step == 2'b11)}) begin
          bad++;
          $display("FAIL rand_data[%0d] got bin=%0d step=%0d first=%b err=%b want %0d,%0d,%b,%b",
                   c, w_out_bin, w_out_step, w_out_first, w_out_err, m_bin, m_step, m_first, m_step == 2'b11);
        end
      end
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 5))
        0:       b = m_prev;
        1, 2:    b = m_prev + 4'd1;
        3:       b = m_prev - 4'd1;
        default: b = 4'($urandom_range(0, 15));
      endcase
      g = b ^ (b >> 1);
      w_in_valid = iv; w_in_gray = iv ? g : 4'($urandom_range(0, 15)); w_out_ready = ordy;
      #1;
      total++;
      if (w_in_ready !== (!m_valid || ordy)) begin
        bad++;
        $display("FAIL rand_ready[%0d] got %b want %b", c, w_in_ready, !m_valid || ordy);
      end
      if (iv && (!m_valid || ordy)) begin
        b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
        diff = (int'(b) - int'(m_prev) + 16) % 16;
        if (!m_started) m_step = 2'b00;
        else if (diff == 0) m_step = 2'b00;
        else if (diff == 1) m_step = 2'b01;
        else if (diff == 15) m_step = 2'b10;
        else m_step = 2'b11;
        if (m_started && diff != 0 && diff != 1 && diff != 15 && m_cnt < 255) m_cnt++;
        m_first = !m_started;
        m_started = 1'b1;
        m_bin = b;
        m_prev = b;
        m_valid = 1'b1;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    w_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_gray = 2'b00; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_gray = 4'd0; w_out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_count_up();
    test_count_down();
    test_jump();
    test_backpressure();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
